// File: rtl/pwm_gen_if.sv
// Configuration and waveform signals between the CPU-side register block and pwm_gen.
// cfg_dt is always present so the port list is identical whether PWM_DEADTIME_EN is defined or not.
interface pwm_gen_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DT_WIDTH = 4
);
  logic                en;
  logic                cfg_wr;
  logic [WIDTH-1:0]    cfg_period;
  logic [WIDTH-1:0]    cfg_duty;
  logic [DT_WIDTH-1:0] cfg_dt;
  logic                pwm_out;
  logic                pwm_out_n;
  logic                cyc_start;
  logic                upd_pending;

  modport master (
    output en, cfg_wr, cfg_period, cfg_duty, cfg_dt,
    input  pwm_out, pwm_out_n, cyc_start, upd_pending
  );

  modport slave (
    input  en, cfg_wr, cfg_period, cfg_duty, cfg_dt,
    output pwm_out, pwm_out_n, cyc_start, upd_pending
  );
endinterface

// File: rtl/pwm_gen.sv
// Double-buffered PWM generator with a registered cycle-start pulse.
// Define PWM_DEADTIME_EN to add the complementary output with programmable dead time.
module pwm_gen #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DT_WIDTH = 4
) (
  input logic     clk,
  input logic     rst_n,
  pwm_gen_if.slave bus
);

  logic [WIDTH-1:0] stg_period, stg_duty;
  logic [WIDTH-1:0] act_period, act_duty;
  logic [WIDTH-1:0] cnt;
  logic             upd_pending_q;
  logic             pwm_q;
  logic             cyc_q;

  logic boundary, raw, wr_thru, promote, load_stg, settle;

  assign boundary = bus.en && (cnt == act_period);
  assign raw      = bus.en && (cnt < act_duty);
  // Active values may change on a period boundary or at any time while stopped.
  assign settle   = !bus.en || boundary;
  assign wr_thru  = boundary && bus.cfg_wr;
  assign promote  = settle && upd_pending_q && !wr_thru;
  assign load_stg = bus.cfg_wr && !boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (settle) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_period    <= '1;
      stg_duty      <= '0;
      act_period    <= '1;
      act_duty      <= '0;
      upd_pending_q <= 1'b0;
    end else begin
      if (load_stg) begin
        stg_period <= bus.cfg_period;
        stg_duty   <= bus.cfg_duty;
      end
      if (wr_thru) begin
        act_period <= bus.cfg_period;
        act_duty   <= bus.cfg_duty;
      end else if (promote) begin
        act_period <= stg_period;
        act_duty   <= stg_duty;
      end
      if (load_stg) begin
        upd_pending_q <= 1'b1;
      end else if (settle) begin
        upd_pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 1'b0;
    end else begin
      cyc_q <= bus.en && (cnt == '0);
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [DT_WIDTH:0] RUN_SAT = {1'b1, {DT_WIDTH{1'b0}}};

  logic [DT_WIDTH-1:0] stg_dt, act_dt;
  logic [DT_WIDTH:0]   run_q, run_now;
  logic                raw_q;
  logic                pwm_n_q;
  logic                settled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_dt <= '0;
      act_dt <= '0;
    end else begin
      if (load_stg) begin
        stg_dt <= bus.cfg_dt;
      end
      if (wr_thru) begin
        act_dt <= bus.cfg_dt;
      end else if (promote) begin
        act_dt <= stg_dt;
      end
    end
  end

  // run_now counts consecutive clocks (this one included) that raw has held its
  // value, saturating above any dead time; an output may assert only once raw
  // has been stable for more than act_dt clocks, which also swallows short pulses.
  always_comb begin
    run_now = RUN_SAT;
    if (raw != raw_q) begin
      run_now = (DT_WIDTH+1)'(1);
    end else if (!run_q[DT_WIDTH]) begin
      run_now = run_q + 1'b1;
    end else begin
      run_now = run_q;
    end
  end

  assign settled = run_now > {1'b0, act_dt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q   <= 1'b0;
      run_q   <= RUN_SAT;
      pwm_q   <= 1'b0;
      pwm_n_q <= 1'b0;
    end else begin
      raw_q   <= raw;
      run_q   <= run_now;
      pwm_q   <= raw && settled;
      pwm_n_q <= bus.en && !raw && settled;
    end
  end

  assign bus.pwm_out_n = pwm_n_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= raw;
    end
  end

  assign bus.pwm_out_n = 1'b0;
`endif

  assign bus.pwm_out     = pwm_q;
  assign bus.cyc_start   = cyc_q;
  assign bus.upd_pending = upd_pending_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: configuration table, directed corner sequences,
// and randomized traffic against a period-level reference model.
module tb_pwm_gen;
  localparam int unsigned W  = 8;
  localparam int unsigned DW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_gen_if #(.WIDTH(W), .DT_WIDTH(DW)) bus ();
  pwm_gen #(.WIDTH(W), .DT_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int m_cnt, m_ap, m_ad, m_adt, m_sp, m_sd, m_sdt;
  bit m_pend;
  bit hist [0:31];
  bit e_pwm, e_n, e_cyc;

  typedef struct {
    int p; int d; int dt;
    int hi;      // expected high clocks per period, plain build
    int hi_dt;   // expected pwm_out high clocks per period, dead-time build
    int n_dt;    // expected pwm_out_n high clocks per period, dead-time build
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit en, input bit wr, input int p, input int d, input int dt);
    bus.en         = en;
    bus.cfg_wr     = wr;
    bus.cfg_period = W'(p);
    bus.cfg_duty   = W'(d);
    bus.cfg_dt     = DW'(dt);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ap = 255; m_ad = 0; m_adt = 0;
    m_sp = 255; m_sd = 0; m_sdt = 0; m_pend = 0;
    for (int i = 0; i < 32; i++) hist[i] = 0;
    e_pwm = 0; e_n = 0; e_cyc = 0;
  endtask

  // One clock of the specification's rules, using the inputs present at the edge.
  task automatic model_step();
    bit raw;
    raw   = bus.en && (m_cnt < m_ad);
    e_cyc = bus.en && (m_cnt == 0);
`ifdef PWM_DEADTIME_EN
    for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = raw;
    e_pwm = 1; e_n = bus.en;
    for (int i = 0; i <= m_adt; i++) begin
      if (!hist[i]) e_pwm = 0;
      if (hist[i])  e_n   = 0;
    end
`else
    e_pwm = raw;
    e_n   = 0;
`endif
    if (!bus.en) begin
      m_cnt = 0;
      if (m_pend) begin m_ap = m_sp; m_ad = m_sd; m_adt = m_sdt; end
      m_pend = 0;
      if (bus.cfg_wr) begin
        m_sp = bus.cfg_period; m_sd = bus.cfg_duty; m_sdt = bus.cfg_dt; m_pend = 1;
      end
    end else if (m_cnt == m_ap) begin
      m_cnt = 0;
      if (bus.cfg_wr) begin
        m_ap = bus.cfg_period; m_ad = bus.cfg_duty; m_adt = bus.cfg_dt;
      end else if (m_pend) begin
        m_ap = m_sp; m_ad = m_sd; m_adt = m_sdt;
      end
      m_pend = 0;
    end else begin
      m_cnt++;
      if (bus.cfg_wr) begin
        m_sp = bus.cfg_period; m_sd = bus.cfg_duty; m_sdt = bus.cfg_dt; m_pend = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("pwm_out",     bus.pwm_out,     e_pwm);
    check("pwm_out_n",   bus.pwm_out_n,   e_n);
    check("cyc_start",   bus.cyc_start,   e_cyc);
    check("upd_pending", bus.upd_pending, m_pend);
    bus.cfg_wr = 1'b0;
  endtask

  // Runs until the model counter reaches target; a missed target is a failure.
  task automatic run_to_cnt(input int target);
    for (int i = 0; i < 600 && m_cnt != target; i++) step();
    if (m_cnt != target) begin
      miscompares++;
      $display("FAIL run_to_cnt: timeout waiting for cnt %0d", target);
    end
  endtask

  task automatic apply_stopped(input int p, input int d, input int dt);
    drive(0, 1, p, d, dt); step();
    drive(0, 0, p, d, dt); step();
  endtask

  initial begin
    int hi, nn, cs, exp_hi, exp_n, len;

    tbl[0] = '{p:9,  d:3,   dt:0, hi:3,   hi_dt:3,   n_dt:7};
    tbl[1] = '{p:9,  d:5,   dt:2, hi:5,   hi_dt:3,   n_dt:3};
    tbl[2] = '{p:9,  d:1,   dt:2, hi:1,   hi_dt:0,   n_dt:7};
    tbl[3] = '{p:9,  d:0,   dt:3, hi:0,   hi_dt:0,   n_dt:10};
    tbl[4] = '{p:99, d:200, dt:1, hi:100, hi_dt:100, n_dt:0};
    tbl[5] = '{p:0,  d:1,   dt:0, hi:1,   hi_dt:1,   n_dt:0};
    tbl[6] = '{p:4,  d:4,   dt:1, hi:4,   hi_dt:3,   n_dt:0};
    tbl[7] = '{p:6,  d:3,   dt:0, hi:3,   hi_dt:3,   n_dt:4};

    drive(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("rst_pwm_out",     bus.pwm_out,     1'b0);
    check("rst_pwm_out_n",   bus.pwm_out_n,   1'b0);
    check("rst_cyc_start",   bus.cyc_start,   1'b0);
    check("rst_upd_pending", bus.upd_pending, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: settle each setting, then measure one full steady-state period.
    for (int i = 0; i < 8; i++) begin
      apply_stopped(tbl[i].p, tbl[i].d, tbl[i].dt);
      drive(1, 0, tbl[i].p, tbl[i].d, tbl[i].dt);
      len = tbl[i].p + 1;
      hi = 0; nn = 0; cs = 0;
      for (int c = 0; c < 3 * len; c++) begin
        step();
        if (c >= 2 * len) begin
          hi += int'(bus.pwm_out);
          nn += int'(bus.pwm_out_n);
          cs += int'(bus.cyc_start);
        end
      end
`ifdef PWM_DEADTIME_EN
      exp_hi = tbl[i].hi_dt; exp_n = tbl[i].n_dt;
`else
      exp_hi = tbl[i].hi; exp_n = 0;
`endif
      check($sformatf("tbl%0d_high", i),  hi, exp_hi);
      check($sformatf("tbl%0d_nhigh", i), nn, exp_n);
      check($sformatf("tbl%0d_cyc", i),   cs, 1);
    end

    // Mid-period write is deferred to the next boundary.
    apply_stopped(9, 3, 0);
    drive(1, 0, 9, 3, 0);
    run_to_cnt(4);
    drive(1, 1, 9, 7, 0);
    step();
    check("midwr_pending", bus.upd_pending, 1'b1);
    hi = 0;
    for (int c = 0; c < 5; c++) begin step(); hi += int'(bus.pwm_out); end
    check("midwr_old_tail", hi, 0);
    hi = 0;
    for (int c = 0; c < 10; c++) begin step(); hi += int'(bus.pwm_out); end
    check("midwr_new_high", hi, 7);

    // Write on the boundary clock goes straight to the active set.
    run_to_cnt(9);
    drive(1, 1, 9, 2, 0);
    step();
    check("thru_pending", bus.upd_pending, 1'b0);
    hi = 0;
    for (int c = 0; c < 10; c++) begin step(); hi += int'(bus.pwm_out); end
    check("thru_high", hi, 2);

    // Stage a change, drop en mid-high, then restart.
    run_to_cnt(1);
    drive(1, 1, 5, 4, 0);
    step();
    drive(0, 0, 5, 4, 0);
    step();
    check("stop_pwm",     bus.pwm_out,     1'b0);
    check("stop_cyc",     bus.cyc_start,   1'b0);
    check("stop_applied", bus.upd_pending, 1'b0);
    step();
    drive(1, 0, 5, 4, 0);
    step();
    check("restart_cyc", bus.cyc_start, 1'b1);
    check("restart_pwm", bus.pwm_out,   1'b1);
    hi = 1;
    for (int c = 0; c < 5; c++) begin step(); hi += int'(bus.pwm_out); end
    check("restart_high", hi, 4);

    // Asynchronous reset in the middle of a high phase, with a staged write pending.
    apply_stopped(20, 15, 1);
    drive(1, 0, 20, 15, 1);
    run_to_cnt(6);
    drive(1, 1, 3, 1, 0);
    step();
    rst_n = 1'b0;
    #2;
    check("arst_pwm_out",     bus.pwm_out,     1'b0);
    check("arst_pwm_out_n",   bus.pwm_out_n,   1'b0);
    check("arst_cyc_start",   bus.cyc_start,   1'b0);
    check("arst_upd_pending", bus.upd_pending, 1'b0);
    model_reset();
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0; cs = 0;
    for (int c = 0; c < 512; c++) begin
      step();
      hi += int'(bus.pwm_out);
      cs += int'(bus.cyc_start);
    end
    check("post_rst_high", hi, 0);
    check("post_rst_cyc",  cs, 2);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit en_r, wr_r;
      int d_r;
      en_r = ($urandom_range(0, 24) != 0);
      wr_r = ($urandom_range(0, 11) == 0);
      d_r  = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 18));
      drive(en_r, wr_r, int'($urandom_range(0, 15)), d_r, int'($urandom_range(0, 4)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
